// File: rtl/stopwatch_pkg.sv
// Shared constants and state encoding for the stopwatch timekeeping core.
package stopwatch_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } run_state_t;

endpackage

// File: rtl/stopwatch_counter_if.sv
// Strobe, control and display signals of the stopwatch counter.
// master = the side driving strobes/controls, slave = the counter core.
interface stopwatch_counter_if;
    import stopwatch_pkg::*;

    logic             tick_1hz;
    logic             tick_2hz;
    logic             pause_btn;
    logic             clr_btn;
    logic             adj;
    logic             sel;
    logic [BCD_W-1:0] min_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
    logic             paused;
    logic             adj_active;
    logic             sel_sec;
    logic             rollover;

    modport master (
        output tick_1hz, tick_2hz, pause_btn, clr_btn, adj, sel,
        input  min_tens, min_ones, sec_tens, sec_ones,
        input  paused, adj_active, sel_sec, rollover
    );

    modport slave (
        input  tick_1hz, tick_2hz, pause_btn, clr_btn, adj, sel,
        output min_tens, min_ones, sec_tens, sec_ones,
        output paused, adj_active, sel_sec, rollover
    );

endinterface

// File: rtl/stopwatch_counter_bcd.sv
// Two-digit BCD counter that wraps to 00 after LIMIT.
// carry is combinational: high when an increment is requested at LIMIT.
module bcd_mod_counter
    import stopwatch_pkg::*;
#(
    parameter int LIMIT = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             carry
);

    localparam logic [BCD_W-1:0] LIM_TENS = BCD_W'(LIMIT / 10);
    localparam logic [BCD_W-1:0] LIM_ONES = BCD_W'(LIMIT % 10);

    logic [BCD_W-1:0] tens_reg;
    logic [BCD_W-1:0] ones_reg;
    logic             at_limit;

    assign at_limit = (tens_reg == LIM_TENS) && (ones_reg == LIM_ONES);
    assign carry    = inc && at_limit;
    assign tens     = tens_reg;
    assign ones     = ones_reg;

    // Clear wins over increment; increment wraps at LIMIT, else ripples ones into tens.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tens_reg <= '0;
            ones_reg <= '0;
        end else if (inc) begin
            if (at_limit) begin
                tens_reg <= '0;
                ones_reg <= '0;
            end else if (ones_reg == BCD_MAX) begin
                ones_reg <= '0;
                tens_reg <= tens_reg + 1'b1;
            end else begin
                ones_reg <= ones_reg + 1'b1;
            end
        end
    end

    // A digit above 9 means the wrap logic is broken.
    a_bcd_legal: assert property (@(posedge clk) disable iff (rst)
        (tens_reg <= BCD_MAX) && (ones_reg <= BCD_MAX));

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core: counts tick_1hz, adjusts on tick_2hz, run/pause and clear buttons.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int MIN_LIMIT    = 59,
    parameter int SEC_LIMIT    = 59,
    parameter int START_PAUSED = 0
) (
    input  logic                clk,
    input  logic                rst,
    stopwatch_counter_if.slave  bus
);

    localparam run_state_t RESET_STATE = (START_PAUSED != 0) ? ST_PAUSED : ST_RUN;

    logic       pause_q;
    logic       clr_q;
    logic       pause_edge;
    logic       clr_edge;
    run_state_t state_reg;
    logic       paused_reg;
    logic       rollover_reg;
    logic       adj_active_reg;
    logic       sel_sec_reg;

    logic       count_tick;
    logic       adj_tick;
    logic       sec_inc;
    logic       min_inc;
    logic       sec_carry;
    logic       min_carry;

    assign pause_edge = bus.pause_btn & ~pause_q;
    assign clr_edge   = bus.clr_btn & ~clr_q;

    // Counting uses the pre-edge run state, so a pause edge with a tick still counts once.
    assign count_tick = ~bus.adj & (state_reg == ST_RUN) & bus.tick_1hz;
    assign adj_tick   = bus.adj & bus.tick_2hz;
    assign sec_inc    = count_tick | (adj_tick & bus.sel);
    assign min_inc    = (count_tick & sec_carry) | (adj_tick & ~bus.sel);

    // Button history for rising-edge detection; cleared so a held button re-fires after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pause_q <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            pause_q <= bus.pause_btn;
            clr_q   <= bus.clr_btn;
        end
    end

    // Run/pause FSM with registered paused flag; independent of adjust mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= RESET_STATE;
            paused_reg <= (RESET_STATE == ST_PAUSED);
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (pause_edge) begin
                        state_reg  <= ST_PAUSED;
                        paused_reg <= 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (pause_edge) begin
                        state_reg  <= ST_RUN;
                        paused_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg  <= RESET_STATE;
                    paused_reg <= (RESET_STATE == ST_PAUSED);
                end
            endcase
        end
    end

    // Rollover pulses only on a counting wrap of the full MM:SS value, never on adjust or clear.
    always_ff @(posedge clk) begin
        if (rst || clr_edge) begin
            rollover_reg <= 1'b0;
        end else begin
            rollover_reg <= count_tick & sec_carry & min_carry;
        end
    end

    // Registered copies of the switches so the display driver can blink the adjusted field.
    always_ff @(posedge clk) begin
        if (rst) begin
            adj_active_reg <= 1'b0;
            sel_sec_reg    <= 1'b0;
        end else begin
            adj_active_reg <= bus.adj;
            sel_sec_reg    <= bus.sel;
        end
    end

    bcd_mod_counter #(.LIMIT(SEC_LIMIT)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .inc   (sec_inc),
        .clr   (clr_edge),
        .tens  (bus.sec_tens),
        .ones  (bus.sec_ones),
        .carry (sec_carry)
    );

    bcd_mod_counter #(.LIMIT(MIN_LIMIT)) u_min (
        .clk   (clk),
        .rst   (rst),
        .inc   (min_inc),
        .clr   (clr_edge),
        .tens  (bus.min_tens),
        .ones  (bus.min_ones),
        .carry (min_carry)
    );

    assign bus.paused     = paused_reg;
    assign bus.rollover   = rollover_reg;
    assign bus.adj_active = adj_active_reg;
    assign bus.sel_sec    = sel_sec_reg;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter: stimulus pushes expectations, monitor pops and compares.
module tb_stopwatch_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    stopwatch_counter_if sw_bus ();

    stopwatch_counter #(
        .MIN_LIMIT    (59),
        .SEC_LIMIT    (59),
        .START_PAUSED (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sw_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          chk_dig;
        logic [15:0] dig;
        logic        paused;
        logic        rollover;
        logic        adj_active;
        logic        sel_sec;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   stim_done = 1'b0;

    // Current switch levels, remembered so expectations for adj_active/sel_sec follow the drive.
    logic cur_adj = 1'b0;
    logic cur_sel = 1'b0;

    // One clock of stimulus: inputs applied on the falling edge, held across the rising edge.
    task automatic cycle(input logic t1, input logic t2, input logic pb, input logic cb,
                         input logic a, input logic s);
        @(negedge clk);
        sw_bus.tick_1hz  = t1;
        sw_bus.tick_2hz  = t2;
        sw_bus.pause_btn = pb;
        sw_bus.clr_btn   = cb;
        sw_bus.adj       = a;
        sw_bus.sel       = s;
        cur_adj          = a;
        cur_sel          = s;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input bit chk_dig, input logic [15:0] dig,
                              input logic p, input logic r);
        exp_t e;
        e.name       = name;
        e.chk_dig    = chk_dig;
        e.dig        = dig;
        e.paused     = p;
        e.rollover   = r;
        e.adj_active = rst ? 1'b0 : cur_adj;
        e.sel_sec    = rst ? 1'b0 : cur_sel;
        exp_q.push_back(e);
    endtask

    // Monitor: on each falling edge, compare outputs against every pending expectation.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [15:0] act;
            e   = exp_q.pop_front();
            act = {sw_bus.min_tens, sw_bus.min_ones, sw_bus.sec_tens, sw_bus.sec_ones};
            if (e.chk_dig) begin
                checks++;
                if (act !== e.dig) begin
                    errors++;
                    $display("FAIL %s digits: got %h want %h", e.name, act, e.dig);
                end
            end
            checks++;
            if (sw_bus.paused !== e.paused) begin
                errors++;
                $display("FAIL %s paused: got %b want %b", e.name, sw_bus.paused, e.paused);
            end
            checks++;
            if (sw_bus.rollover !== e.rollover) begin
                errors++;
                $display("FAIL %s rollover: got %b want %b", e.name, sw_bus.rollover, e.rollover);
            end
            checks++;
            if (sw_bus.adj_active !== e.adj_active || sw_bus.sel_sec !== e.sel_sec) begin
                errors++;
                $display("FAIL %s adj/sel copy: got %b%b want %b%b", e.name,
                         sw_bus.adj_active, sw_bus.sel_sec, e.adj_active, e.sel_sec);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sw_bus.tick_1hz  = 1'b0;
        sw_bus.tick_2hz  = 1'b0;
        sw_bus.pause_btn = 1'b0;
        sw_bus.clr_btn   = 1'b0;
        sw_bus.adj       = 1'b0;
        sw_bus.sel       = 1'b0;

        // Reset
        rst = 1'b1;
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        expect_out("reset", 1, 16'h0000, 0, 0);
        rst = 1'b0;

        // 61 counting ticks -> 01:01, with the 00:59 -> 01:00 carry checked
        for (int i = 0; i < 61; i++) begin
            cycle(1, 0, 0, 0, 0, 0);
            if (i == 58)      expect_out("count_0059", 1, 16'h0059, 0, 0);
            else if (i == 59) expect_out("count_0100", 1, 16'h0100, 0, 0);
            else              expect_out("count_roll_low", 0, 16'h0000, 0, 0);
        end
        expect_out("count_0101", 1, 16'h0101, 0, 0);

        // Preload 59:58 via adjust: minutes 01 -> 59, seconds 01 -> 58
        for (int i = 0; i < 58; i++) begin
            cycle(0, 1, 0, 0, 1, 0);
            expect_out("adj_min_no_roll", 0, 16'h0000, 0, 0);
        end
        expect_out("adj_min_5901", 1, 16'h5901, 0, 0);
        for (int i = 0; i < 57; i++) begin
            cycle(0, 1, 0, 0, 1, 1);
            expect_out("adj_sec_no_roll", 0, 16'h0000, 0, 0);
        end
        expect_out("adj_5958", 1, 16'h5958, 0, 0);

        // Full wrap: 59:59 then 00:00 with a single rollover pulse
        cycle(1, 0, 0, 0, 0, 0);
        expect_out("wrap_5959", 1, 16'h5959, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        expect_out("wrap_0000", 1, 16'h0000, 0, 1);
        cycle(0, 0, 0, 0, 0, 0);
        expect_out("wrap_pulse_end", 1, 16'h0000, 0, 0);

        // Pause edge coincident with a tick at 00:05
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, 0);
        expect_out("pre_pause_0005", 1, 16'h0005, 0, 0);
        cycle(1, 0, 1, 0, 0, 0);
        expect_out("pause_tick_0006", 1, 16'h0006, 1, 0);
        cycle(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 0, 0);
        expect_out("paused_hold_0006", 1, 16'h0006, 1, 0);
        cycle(0, 0, 1, 0, 0, 0);
        expect_out("resume", 1, 16'h0006, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        expect_out("resume_0007", 1, 16'h0007, 0, 0);

        // Seconds adjust wrap at 00:58, tick_1hz ignored while adjusting
        for (int i = 0; i < 51; i++) cycle(1, 0, 0, 0, 0, 0);
        expect_out("pre_adj_0058", 1, 16'h0058, 0, 0);
        cycle(0, 1, 0, 0, 1, 1);
        expect_out("adj_sec_0059", 1, 16'h0059, 0, 0);
        cycle(1, 0, 0, 0, 1, 1);
        expect_out("adj_ignore_1hz", 1, 16'h0059, 0, 0);
        cycle(0, 1, 0, 0, 1, 1);
        expect_out("adj_sec_wrap_0000", 1, 16'h0000, 0, 0);
        cycle(1, 1, 0, 0, 1, 1);
        expect_out("adj_sec_0001", 1, 16'h0001, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        expect_out("no_adj_ignore_2hz", 1, 16'h0001, 0, 0);

        // Minutes adjust wrap 59 -> 00 without carry or rollover
        for (int i = 0; i < 59; i++) cycle(0, 1, 0, 0, 1, 0);
        expect_out("adj_min_5901b", 1, 16'h5901, 0, 0);
        cycle(0, 1, 0, 0, 1, 0);
        expect_out("adj_min_wrap", 1, 16'h0001, 0, 0);

        // Clear at 12:34 with a coincident tick; held button does not clear again
        for (int i = 0; i < 12; i++) cycle(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 33; i++) cycle(0, 1, 0, 0, 1, 1);
        expect_out("pre_clr_1234", 1, 16'h1234, 0, 0);
        cycle(1, 0, 0, 1, 0, 0);
        expect_out("clr_0000", 1, 16'h0000, 0, 0);
        cycle(1, 0, 0, 1, 0, 0);
        expect_out("clr_held_0001", 1, 16'h0001, 0, 0);
        cycle(1, 0, 0, 1, 0, 0);
        expect_out("clr_held_0002", 1, 16'h0002, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // Reset at 07:07 while paused and pause_btn held
        for (int i = 0; i < 7; i++) cycle(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 1, 1);
        expect_out("pre_rst_0707", 1, 16'h0707, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        expect_out("pre_rst_pause", 1, 16'h0707, 1, 0);
        rst = 1'b1;
        cycle(1, 0, 1, 0, 1, 1);
        cycle(1, 0, 1, 0, 1, 1);
        expect_out("rst_mid", 1, 16'h0000, 0, 0);
        rst = 1'b0;
        cycle(0, 0, 1, 0, 0, 0);
        expect_out("post_rst_edge", 1, 16'h0000, 1, 0);
        cycle(0, 0, 1, 0, 0, 0);
        expect_out("post_rst_held", 1, 16'h0000, 1, 0);
        cycle(1, 0, 0, 0, 0, 0);
        expect_out("post_rst_paused_tick", 1, 16'h0000, 1, 0);

        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        stim_done = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
